// File: rtl/cu_seq.sv
// cu_seq: microcode sequencer for the 8-bit core.
// Fetches an opcode over a handshake channel. It then walks up to STEPS
// micro-steps, and each step may wait on several busy/done channels. The
// microword comes from an external store addressed by uaddr = {ir, step}.
// Optional: define CU_SINGLE_STEP_EN to add the step_req input and a HOLD
// state that parks the sequencer after every instruction.
module cu_seq #(
    parameter int                PC_W        = 16,
    parameter int                IR_W        = 8,
    parameter int                FLAG_W      = 22,
    parameter int                STEPS       = 2,
    parameter int                NWAIT       = 2,
    parameter int                FETCH_CH    = 0,
    parameter logic [FLAG_W-1:0] FETCH_FLAGS = 22'h100200,
    localparam int               STEP_W      = $clog2(STEPS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   halt,
    input  logic [IR_W-1:0]        irin,
    input  logic [NWAIT-1:0]       chan_done,
    output logic [NWAIT-1:0]       chan_exec,
    output logic [IR_W+STEP_W-1:0] uaddr,
    input  logic [FLAG_W-1:0]      uflags,
    input  logic [NWAIT-1:0]       uwait,
    input  logic                   uinc,
    input  logic                   ulast,
    input  logic                   pcinflag,
    input  logic [PC_W-1:0]        pcin,
`ifdef CU_SINGLE_STEP_EN
    input  logic                   step_req,
`endif
    output logic [PC_W-1:0]        pc,
    output logic [FLAG_W-1:0]      flags_noc,
    output logic [FLAG_W-1:0]      flags,
    output logic [STEPS-1:0]       step_strobe,
    output logic [IR_W-1:0]        cuout
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_LATCH,
        S_DECODE,
        S_WAIT,
        S_EVENTS
`ifdef CU_SINGLE_STEP_EN
        , S_HOLD
`endif
    } state_t;

    state_t              r_state;
    logic [PC_W-1:0]     r_pc;
    logic [IR_W-1:0]     r_ir;
    logic [STEP_W-1:0]   r_step;
    logic [NWAIT-1:0]    r_pending;
    logic [NWAIT-1:0]    r_doneQ;

    logic [NWAIT-1:0]    w_complete;
    logic [NWAIT-1:0]    w_active;
    logic [NWAIT-1:0]    w_pendingNext;
    logic                w_activeDone;
    logic                w_fetchDone;
    logic                w_endOfInstr;
    logic [PC_W-1:0]     w_pcInc;
    logic [NWAIT-1:0]    w_exec;
    logic [FLAG_W-1:0]   w_flagsNoc;
    logic                w_flagsEn;
    logic [STEPS-1:0]    w_strobe;

    // A completion is a rising edge on done. The previous level is held in
    // r_doneQ, so a done that is already high never counts.
    assign w_complete    = chan_done & ~r_doneQ;
    // Lowest pending channel is serviced first (x & -x isolates it).
    assign w_active      = r_pending & (~r_pending + NWAIT'(1));
    assign w_pendingNext = r_pending & ~w_active;
    assign w_activeDone  = |(w_complete & w_active);
    assign w_fetchDone   = w_complete[FETCH_CH];
    assign w_endOfInstr  = ulast || (r_step == STEP_W'(STEPS - 1));
    assign w_pcInc       = r_pc + PC_W'(1);

    // Decode the current state into channel requests, flag source and strobe.
    always_comb begin
        w_exec     = '0;
        w_flagsNoc = uflags;
        w_flagsEn  = 1'b0;
        w_strobe   = '0;
        case (r_state)
            S_FETCH: begin
                w_exec[FETCH_CH] = 1'b1;
                w_flagsNoc       = FETCH_FLAGS;
                w_flagsEn        = 1'b1;
            end
            S_LATCH: begin
                w_flagsNoc = FETCH_FLAGS;
                w_flagsEn  = 1'b1;
            end
            S_WAIT: begin
                w_exec = w_active;
            end
            S_EVENTS: begin
                w_flagsEn = 1'b1;
                w_strobe  = STEPS'(1) << r_step;
            end
            default: begin
            end
        endcase
    end

    // Requests are gated by reset so they drop the moment rst rises,
    // without waiting for a clock edge.
    assign chan_exec   = rst ? '0 : w_exec;
    assign flags_noc   = w_flagsNoc;
    assign flags       = w_flagsEn ? w_flagsNoc : '0;
    assign step_strobe = w_strobe;
    assign uaddr       = {r_ir, r_step};
    assign pc          = r_pc;
    assign cuout       = r_ir;

    // Sequencer state machine. halt freezes everything, edge history included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_pc      <= '0;
            r_ir      <= '0;
            r_step    <= '0;
            r_pending <= '0;
            r_doneQ   <= '1;
        end else if (!halt) begin
            r_doneQ <= chan_done;
            case (r_state)
                S_FETCH: begin
                    if (w_fetchDone) begin
                        r_state <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    r_ir    <= irin;
                    r_pc    <= w_pcInc;
                    r_step  <= '0;
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_pending <= uwait;
                    if (uinc) begin
                        r_pc <= w_pcInc;
                    end
                    r_state <= (uwait != '0) ? S_WAIT : S_EVENTS;
                end
                S_WAIT: begin
                    if (w_activeDone) begin
                        r_pending <= w_pendingNext;
                        if (w_pendingNext == '0) begin
                            r_state <= S_EVENTS;
                        end
                    end
                end
                S_EVENTS: begin
                    if (w_endOfInstr) begin
                        // A jump overwrites every increment made in this instruction.
                        r_pc <= pcinflag ? pcin : r_pc;
`ifdef CU_SINGLE_STEP_EN
                        r_state <= S_HOLD;
`else
                        r_state <= S_FETCH;
`endif
                    end else begin
                        r_step  <= r_step + STEP_W'(1);
                        r_state <= S_DECODE;
                    end
                end
`ifdef CU_SINGLE_STEP_EN
                S_HOLD: begin
                    if (step_req) begin
                        r_state <= S_FETCH;
                    end
                end
`endif
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cu_seq.sv
// tb_cu_seq: bench for cu_seq.
// The bench holds a microcode ROM and emulates the channel responders. An
// instruction-level model predicts the channel service order, the strobes
// and the final pc for each opcode.
`timescale 1ns/1ps
module tb_cu_seq;

    localparam int                PC_W        = 16;
    localparam int                IR_W        = 8;
    localparam int                FLAG_W      = 22;
    localparam int                STEPS       = 2;
    localparam int                NWAIT       = 2;
    localparam int                FETCH_CH    = 0;
    localparam int                STEP_W      = $clog2(STEPS);
    localparam int                UA_W        = IR_W + STEP_W;
    localparam int                ROM_N       = 1 << UA_W;
    localparam logic [FLAG_W-1:0] FETCH_FLAGS = 22'h100200;

    logic                clk = 1'b0;
    logic                rst;
    logic                halt;
    logic [IR_W-1:0]     irin;
    logic [NWAIT-1:0]    chanDone;
    logic [NWAIT-1:0]    chanExec;
    logic [UA_W-1:0]     uAddr;
    logic [FLAG_W-1:0]   uFlags;
    logic [NWAIT-1:0]    uWait;
    logic                uInc;
    logic                uLast;
    logic                pcInFlag;
    logic [PC_W-1:0]     pcIn;
    logic [PC_W-1:0]     pc;
    logic [FLAG_W-1:0]   flagsNoc;
    logic [FLAG_W-1:0]   flags;
    logic [STEPS-1:0]    stepStrobe;
    logic [IR_W-1:0]     cuout;
`ifdef CU_SINGLE_STEP_EN
    logic                stepReq;
`endif

    // Microcode ROM, read combinationally at the address the sequencer presents.
    logic [FLAG_W-1:0]   romFlags [ROM_N];
    logic [NWAIT-1:0]    romWait  [ROM_N];
    logic                romInc   [ROM_N];
    logic                romLast  [ROM_N];
    logic                romPcinf [ROM_N];
    logic [PC_W-1:0]     romPcin  [ROM_N];

    assign uFlags   = romFlags[uAddr];
    assign uWait    = romWait[uAddr];
    assign uInc     = romInc[uAddr];
    assign uLast    = romLast[uAddr];
    assign pcInFlag = romPcinf[uAddr];
    assign pcIn     = romPcin[uAddr];

    cu_seq dut (
        .clk         (clk),
        .rst         (rst),
        .halt        (halt),
        .irin        (irin),
        .chan_done   (chanDone),
        .chan_exec   (chanExec),
        .uaddr       (uAddr),
        .uflags      (uFlags),
        .uwait       (uWait),
        .uinc        (uInc),
        .ulast       (uLast),
        .pcinflag    (pcInFlag),
        .pcin        (pcIn),
`ifdef CU_SINGLE_STEP_EN
        .step_req    (stepReq),
`endif
        .pc          (pc),
        .flags_noc   (flagsNoc),
        .flags       (flags),
        .step_strobe (stepStrobe),
        .cuout       (cuout)
    );

    always #5 clk = ~clk;

    int              compared = 0;
    int              mismatched = 0;
    int              expSvc[$];
    int              svcThrough[STEPS];
    int              svcIdx;
    int              strIdx;
    int              lastStep;
    int              sinceFetch;
    int              cnt[NWAIT];
    logic [IR_W-1:0] curOp;
    logic [PC_W-1:0] pcModel;
    logic [PC_W-1:0] pcAfterFetch;
    bit              haltPlan;
    bit              rstPlan;
    bit              abortRun;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic setStep(input logic [IR_W-1:0] op, input int step, input logic [NWAIT-1:0] w,
                           input logic inc, input logic last, input logic pinf, input logic [PC_W-1:0] pin);
        logic [UA_W-1:0] a;
        a = {op, STEP_W'(step)};
        romWait[a]  = w;
        romInc[a]   = inc;
        romLast[a]  = last;
        romPcinf[a] = pinf;
        romPcin[a]  = pin;
    endtask

    // Compare what is visible this cycle against the instruction model.
    task automatic observeCycle();
        logic [31:0] expExec;
        int          expThrough;
        if (svcIdx >= 1) begin
            sinceFetch++;
            if (sinceFetch == 2) begin
                checkOutput("latchIr", cuout, curOp);
                checkOutput("latchPc", pc, pcAfterFetch);
                checkOutput("latchUaddr", uAddr, {curOp, STEP_W'(0)});
            end
        end
        if (chanExec != '0) begin
            expExec = (svcIdx < expSvc.size()) ? (32'(1) << expSvc[svcIdx]) : 32'(0);
            checkOutput("execChan", chanExec, expExec);
            checkOutput("execFlags", flags, (svcIdx == 0) ? FETCH_FLAGS : '0);
        end
        if (stepStrobe != '0) begin
            expThrough = (strIdx <= lastStep) ? svcThrough[strIdx] : -1;
            checkOutput("strobeOnehot", stepStrobe, 32'(1) << strIdx);
            checkOutput("strobeSvcDone", svcIdx, expThrough);
            checkOutput("strobeFlags", flags, romFlags[{curOp, STEP_W'(strIdx)}]);
            strIdx++;
        end else if (chanExec == '0 && svcIdx >= 1) begin
            checkOutput("gatedFlags", 32'(flags == '0 || flags == FETCH_FLAGS), 1);
        end
    endtask

    // Responders: answer requests after a random delay and throw in stray
    // done pulses on idle channels, which the sequencer has to ignore.
    task automatic driveResponders();
        for (int i = 0; i < NWAIT; i++) begin
            if (chanDone[i]) begin
                chanDone[i] = 1'b0;
            end else if (chanExec[i]) begin
                if (cnt[i] == 0) begin
                    chanDone[i] = 1'b1;
                    svcIdx++;
                    cnt[i] = $urandom_range(0, 4);
                end else begin
                    cnt[i]--;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                chanDone[i] = 1'b1;
            end
        end
    endtask

    // Freeze for five cycles while the awaited done toggles. The final
    // toggle leaves done high, so the edge lands once halt drops.
    task automatic doHaltBurst();
        int               ch;
        logic [NWAIT-1:0] execHeld;
        logic [PC_W-1:0]  pcHeld;
        logic [UA_W-1:0]  uaHeld;
        ch       = expSvc[svcIdx];
        execHeld = chanExec;
        pcHeld   = pc;
        uaHeld   = uAddr;
        haltPlan = 1'b0;
        halt     = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chanDone[ch] = ~chanDone[ch];
            @(negedge clk);
            #1;
            checkOutput("haltExec", chanExec, execHeld);
            checkOutput("haltPc", pc, pcHeld);
            checkOutput("haltUaddr", uAddr, uaHeld);
        end
        halt = 1'b0;
        svcIdx++;
        cnt[ch] = $urandom_range(0, 3);
    endtask

    // Assert reset in the middle of a wait. The checks run before any clock edge.
    task automatic doResetBurst();
        rstPlan = 1'b0;
        rst     = 1'b1;
        #1;
        checkOutput("rstExec", chanExec, 0);
        checkOutput("rstPc", pc, 0);
        checkOutput("rstIr", cuout, 0);
        checkOutput("rstStrobe", stepStrobe, 0);
        checkOutput("rstFlags", flags, FETCH_FLAGS);
        chanDone = '0;
        for (int i = 0; i < NWAIT; i++) cnt[i] = 0;
        @(negedge clk);
        rst      = 1'b0;
        pcModel  = '0;
        abortRun = 1'b1;
    endtask

    task automatic applyStimulus();
        bit inWait;
        @(negedge clk);
        #1;
        observeCycle();
        inWait = (svcIdx >= 1) && (svcIdx < expSvc.size()) && (chanExec != '0) && (chanDone == '0);
        if (haltPlan && inWait) doHaltBurst();
        else if (rstPlan && inWait) doResetBurst();
        else driveResponders();
    endtask

    // Build the instruction-level expectation, then run it cycle by cycle.
    task automatic runInstruction(input logic [IR_W-1:0] op);
        logic [UA_W-1:0] a;
        logic [PC_W-1:0] p;
        curOp = op;
        irin  = op;
        expSvc.delete();
        expSvc.push_back(FETCH_CH);
        pcAfterFetch = pcModel + 1'b1;
        p            = pcAfterFetch;
        lastStep     = STEPS - 1;
        for (int k = 0; k < STEPS; k++) begin
            a = {op, STEP_W'(k)};
            for (int i = 0; i < NWAIT; i++) if (romWait[a][i]) expSvc.push_back(i);
            svcThrough[k] = expSvc.size();
            if (romInc[a]) p = p + 1'b1;
            if (romLast[a] || k == STEPS - 1) begin
                lastStep = k;
                if (romPcinf[a]) p = romPcin[a];
                break;
            end
        end
        svcIdx     = 0;
        strIdx     = 0;
        sinceFetch = 0;
        abortRun   = 1'b0;
        for (int cyc = 0; cyc < 400 && strIdx <= lastStep && !abortRun; cyc++) applyStimulus();
        if (abortRun) return;
        checkOutput("runDone", strIdx, lastStep + 1);
        @(posedge clk);
        #1;
        checkOutput("endPc", pc, p);
        checkOutput("endIr", cuout, op);
        checkOutput("endUaddr", uAddr, {op, STEP_W'(lastStep)});
        checkOutput("endSvc", svcIdx, expSvc.size());
        pcModel = p;
`ifdef CU_SINGLE_STEP_EN
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            checkOutput("holdExec", chanExec, 0);
            checkOutput("holdFlags", flags, 0);
        end
        stepReq = 1'b1;
        @(negedge clk);
        stepReq = 1'b0;
`endif
    endtask

    initial begin
        rst      = 1'b1;
        halt     = 1'b0;
        irin     = '0;
        chanDone = '1;
        haltPlan = 1'b0;
        rstPlan  = 1'b0;
        abortRun = 1'b0;
        pcModel  = '0;
`ifdef CU_SINGLE_STEP_EN
        stepReq  = 1'b0;
`endif
        for (int i = 0; i < NWAIT; i++) cnt[i] = 0;
        for (int a = 0; a < ROM_N; a++) begin
            romFlags[a] = FLAG_W'($urandom);
            romWait[a]  = NWAIT'($urandom);
            romInc[a]   = 1'($urandom);
            romLast[a]  = ($urandom_range(0, 1) == 0);
            romPcinf[a] = ($urandom_range(0, 7) == 0);
            romPcin[a]  = PC_W'($urandom);
        end

        // Reset values while rst is held.
        repeat (2) @(negedge clk);
        #1;
        checkOutput("resetPc", pc, 0);
        checkOutput("resetIr", cuout, 0);
        checkOutput("resetExec", chanExec, 0);
        checkOutput("resetFlags", flags, FETCH_FLAGS);
        checkOutput("resetFlagsNoc", flagsNoc, FETCH_FLAGS);
        checkOutput("resetStrobe", stepStrobe, 0);
        checkOutput("resetUaddr", uAddr, 0);
        @(negedge clk);
        rst = 1'b0;

        // Two waits in step 0 and an increment in each step: 1 + 2 = 3.
        setStep(8'h3A, 0, 2'b11, 1'b1, 1'b0, 1'b0, 16'h0000);
        setStep(8'h3A, 1, 2'b00, 1'b1, 1'b1, 1'b0, 16'h0000);
        runInstruction(8'h3A);
        checkOutput("tpIncPc", pc, 16'd3);

        // The jump in the last step wins over the increment in that step.
        setStep(8'hC4, 0, 2'b01, 1'b0, 1'b0, 1'b0, 16'h0000);
        setStep(8'hC4, 1, 2'b10, 1'b1, 1'b1, 1'b1, 16'hBEEF);
        runInstruction(8'hC4);
        checkOutput("tpJumpPc", pc, 16'hBEEF);

        // Park pc at 16'hFFFF, so the next fetch wraps it to 0.
        setStep(8'h77, 0, 2'b00, 1'b0, 1'b1, 1'b1, 16'hFFFF);
        runInstruction(8'h77);
        checkOutput("tpParkPc", pc, 16'hFFFF);

        setStep(8'h55, 0, 2'b10, 1'b0, 1'b1, 1'b0, 16'h0000);
        haltPlan = 1'b1;
        runInstruction(8'h55);
        checkOutput("tpWrapPc", pc, 16'h0000);
        checkOutput("tpHaltSeen", haltPlan, 0);

        // Random opcodes over the random ROM.
        for (int n = 0; n < 30; n++) runInstruction(IR_W'($urandom));

        // Reset in the middle of a wait, then restart from pc 0.
        setStep(8'h99, 0, 2'b11, 1'b1, 1'b1, 1'b0, 16'h0000);
        rstPlan = 1'b1;
        runInstruction(8'h99);
        checkOutput("tpRstSeen", rstPlan, 0);
        setStep(8'h3A, 0, 2'b11, 1'b1, 1'b0, 1'b0, 16'h0000);
        setStep(8'h3A, 1, 2'b00, 1'b1, 1'b1, 1'b0, 16'h0000);
        runInstruction(8'h3A);
        checkOutput("tpAfterRstPc", pc, 16'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cu_seq.md
Name: cu_seq

Overview:
- Parametrised microcode sequencer; next-generation control unit for the 8-bit core.
- Fetches an instruction through a handshake channel, then runs up to STEPS micro-steps per opcode. Each micro-step may wait on any subset of NWAIT busy/done handshake channels (SPI memory, ALU, future peripherals).
- Microcode storage is external: the block presents a micro-address and consumes the returned microword combinationally.
- Sits between the SPI/ROM fetch path, the ALU and the datapath flag decoder.

Parameters:
- PC_W, 16, program counter width
- IR_W, 8, instruction register width
- FLAG_W, 22, control flag vector width
- STEPS, 2, maximum micro-steps per instruction (>=2); STEP_W = $clog2(STEPS)
- NWAIT, 2, number of handshake channels
- FETCH_CH, 0, channel index used for instruction fetch
- FETCH_FLAGS, 22'h100200, flags driven during fetch (PCC|ROMO)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- halt  in  1  freezes all state while high
- irin  in  IR_W  fetched opcode
- chan_done  in  NWAIT  per-channel done level
- chan_exec  out  NWAIT  per-channel execute request
- uaddr  out  IR_W+STEP_W  {ir, step} microcode address
- uflags  in  FLAG_W  microword flags for uaddr
- uwait  in  NWAIT  channels this micro-step must wait on
- uinc  in  1  increment PC once in this micro-step
- ulast  in  1  this micro-step ends the instruction
- pcinflag  in  1  load pcin at end of instruction
- pcin  in  PC_W  jump target
- pc  out  PC_W  program counter
- flags_noc  out  FLAG_W  current flags, ungated
- flags  out  FLAG_W  flags gated to event cycles
- step_strobe  out  STEPS  one-hot, high in EVENTS of step k
- cuout  out  IR_W  current instruction register

Behaviour:
- Reset:
  - pc=0, ir=0, step=0, state=FETCH, pending=0, done_q=all ones.
  - Outputs: chan_exec=0, flags=FETCH_FLAGS, step_strobe=0.
- halt=1: no register updates, including done_q. Combinational outputs follow the held state.
- Edge detect: done_q<=chan_done every non-halted cycle. Completion of channel i = chan_done[i] & ~done_q[i].
- FETCH:
  - chan_exec[FETCH_CH]=1 until completion.
  - On completion -> LATCH.
- LATCH: ir<=irin; pc<=pc+1; step<=0 -> DECODE.
- DECODE:
  - pending<=uwait.
  - If uinc: pc<=pc+1.
  - If uwait!=0 -> WAIT, else -> EVENTS.
- WAIT:
  - Active channel = lowest set bit of pending; only that chan_exec bit is high.
  - On its completion: clear that bit. If it was the last bit -> EVENTS, else stay.
  - Completions on non-active channels are ignored.
- EVENTS (one cycle):
  - step_strobe[step]=1.
  - If ulast or step==STEPS-1: pc<=pcinflag ? pcin : pc; -> FETCH.
  - Else: step<=step+1 -> DECODE.
- Flag outputs:
  - flags_noc = FETCH_FLAGS in FETCH/LATCH, else uflags.
  - flags = flags_noc in FETCH/LATCH/EVENTS, else 0.
- Addressing: uaddr={ir,step} at all times. cuout=ir.
- pc wraps modulo 2^PC_W.
- pcinflag has priority over any uinc already applied in that instruction; the load overwrites.
- A done already high when WAIT is entered is not a completion; a new rising edge is required.
- rst mid-operation: immediate return to reset values; chan_exec drops asynchronously.

Optional Feature:
- Macro CU_SINGLE_STEP_EN adds input step_req (1 bit) and state HOLD.
- Defined: the end-of-instruction EVENTS goes to HOLD instead of FETCH.
  - In HOLD: all outputs idle (chan_exec=0, flags=0).
  - A step_req high for one non-halted cycle -> FETCH.
  - step_req seen in any other state is ignored.
- Undefined: no port, no HOLD; behaviour as above.

Test Plan:
- Reset then FETCH_CH done pulse with irin=8'h3A -> cuout=8'h3A, pc=1, uaddr={8'h3A,0}, flags=FETCH_FLAGS during fetch.
- Step 0 uwait=2'b11 with ALU done edge first, then SPI -> chan_exec[0] held until ch0 edge, then chan_exec[1]; early ch1 edge ignored; single step_strobe[0].
- uinc=1 in steps 0 and 1, ulast at step 1, pcinflag=0 -> pc advances 1+2=3 per instruction; flags nonzero only in EVENTS cycles.
- ulast at step 1, pcinflag=1, pcin=16'hBEEF -> pc=16'hBEEF, next FETCH.
- pc=16'hFFFF with fetch increment -> pc=0; halt asserted in WAIT for 5 cycles with done toggling -> no state change, edge recognised only after halt drops.
- CU_SINGLE_STEP_EN: instruction ends -> HOLD, no chan_exec until step_req pulse; rst asserted in WAIT -> chan_exec=0 asynchronously, pc=0.
